counter_checker: RTL and testbench

Hardware sequence monitor that sits on the far side of the counter's `inf` interface and consumes its output. It tracks the count value and enable, predicts the next value, and flags every deviation with a pulse, a saturating error counter, and a capture of the offending value. It is instantiated next to `counter` in `testbench_top` and is synthesizable for on-chip self-check.

---
 rtl/counter_checker.sv | 103 ++++++++++
 tb/tb_counter_checker.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_checker.sv
// Watches a free-running counter, predicts each next value and flags deviations once locked.
// Every output is registered and updates on the edge that samples the input; there is no backpressure.
module counter_checker #(
   parameter int WIDTH       = 4,
   parameter int LOCK_CYCLES = 4,
   parameter int ERR_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] cnt_in,
   input  logic             cnt_en,
   input  logic             clr_stats,
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_count,
   output logic             sticky_err,
   output logic [WIDTH-1:0] bad_value,
   output logic [WIDTH-1:0] exp_value
);

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      SYNC     = 2'd1,
      LOCKED   = 2'd2
   } state_t;

   localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CYCLES);
   localparam logic [ERR_W-1:0] ERR_MAX  = '1;

   state_t           state;
   logic [3:0]       match_cnt;
   logic [3:0]       match_nxt;
   logic             hit;
   logic [WIDTH-1:0] next_exp;
   logic [ERR_W-1:0] err_base;
   logic [ERR_W-1:0] err_inc;

   assign hit       = (cnt_in == exp_value);
   assign next_exp  = cnt_in + WIDTH'(cnt_en);
   assign match_nxt = match_cnt + 4'd1;

   // A clear on the same edge as an error counts that error against a zeroed total.
   assign err_base = clr_stats ? '0 : err_count;
   assign err_inc  = (err_base == ERR_MAX) ? err_base : err_base + ERR_W'(1);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= UNLOCKED;
         match_cnt  <= '0;
         locked     <= 1'b0;
         err_pulse  <= 1'b0;
         err_count  <= '0;
         sticky_err <= 1'b0;
         bad_value  <= '0;
         exp_value  <= '0;
      end else begin
         err_pulse <= 1'b0;
         exp_value <= next_exp;

         if (clr_stats) begin
            err_count  <= '0;
            sticky_err <= 1'b0;
            bad_value  <= '0;
         end

         case (state)
            UNLOCKED: begin
               state     <= SYNC;
               match_cnt <= '0;
               locked    <= 1'b0;
            end
            SYNC: begin
               if (hit) begin
                  match_cnt <= match_nxt;
                  if (match_nxt == LOCK_TGT) begin
                     state  <= LOCKED;
                     locked <= 1'b1;
                  end
               end else begin
                  match_cnt <= '0;
               end
            end
            LOCKED: begin
               if (!hit) begin
                  err_pulse  <= 1'b1;
                  err_count  <= err_inc;
                  sticky_err <= 1'b1;
                  bad_value  <= cnt_in;
                  match_cnt  <= '0;
                  state      <= SYNC;
                  locked     <= 1'b0;
               end
            end
            default: begin
               state     <= UNLOCKED;
               match_cnt <= '0;
               locked    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_counter_checker.sv
// Scoreboard bench for counter_checker: a stream-level model predicts every cycle's outputs.
module tb_counter_checker;

   localparam int WIDTH = 4;
   localparam int LOCK  = 4;
   localparam int ERR_W = 8;
   localparam int MODV  = 1 << WIDTH;
   localparam int EMAX  = (1 << ERR_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [WIDTH-1:0] cnt_in = '0;
   logic             cnt_en = 1'b0;
   logic             clr_stats = 1'b0;
   logic             locked;
   logic             err_pulse;
   logic [ERR_W-1:0] err_count;
   logic             sticky_err;
   logic [WIDTH-1:0] bad_value;
   logic [WIDTH-1:0] exp_value;

   counter_checker #(.WIDTH(WIDTH), .LOCK_CYCLES(LOCK), .ERR_W(ERR_W)) dut (
      .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_en(cnt_en), .clr_stats(clr_stats),
      .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
      .sticky_err(sticky_err), .bad_value(bad_value), .exp_value(exp_value)
   );

   always #5 clk = ~clk;

   typedef struct {
      int lk;
      int pulse;
      int cnt;
      int sticky;
      int bad;
      int expv;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference: "free" = waiting for first sample, "tracking" = counting good samples, "trusted" = locked.
   int m_phase  = 0;
   int m_streak = 0;
   int m_pred   = 0;
   int m_errs   = 0;
   int m_sticky = 0;
   int m_bad    = 0;
   int m_pulse  = 0;
   int cur      = 0;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_step(input int v, input int en, input int clr, input int rs);
      if (rs == 0) begin
         m_phase = 0; m_streak = 0; m_pred = 0;
         m_errs = 0; m_sticky = 0; m_bad = 0; m_pulse = 0;
         return;
      end
      m_pulse = 0;
      if (clr != 0) begin
         m_errs = 0; m_sticky = 0; m_bad = 0;
      end
      if (m_phase == 0) begin
         m_phase = 1;
         m_streak = 0;
      end else if (m_phase == 1) begin
         if (v == m_pred) begin
            m_streak = m_streak + 1;
            if (m_streak >= LOCK) m_phase = 2;
         end else begin
            m_streak = 0;
         end
      end else if (v != m_pred) begin
         m_pulse  = 1;
         m_errs   = (m_errs + 1 > EMAX) ? EMAX : m_errs + 1;
         m_sticky = 1;
         m_bad    = v;
         m_phase  = 1;
         m_streak = 0;
      end
      m_pred = (v + en) % MODV;
   endtask

   task automatic drive(input int v, input int en, input int clr, input int rs);
      exp_t e;
      @(negedge clk);
      cnt_in    = WIDTH'(v);
      cnt_en    = (en != 0);
      clr_stats = (clr != 0);
      rst       = (rs != 0);
      model_step(v, en, clr, rs);
      e.lk = (m_phase == 2) ? 1 : 0;
      e.pulse = m_pulse; e.cnt = m_errs; e.sticky = m_sticky;
      e.bad = m_bad; e.expv = m_pred;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0);
      drive(0, 0, 0, 0);
      cur = 0;
   endtask

   task automatic clean(input int n);
      for (int i = 0; i < n; i++) begin
         drive(cur, 1, 0, 1);
         cur = (cur + 1) % MODV;
      end
   endtask

   task automatic lock_up();
      int guard;
      guard = 0;
      while (m_phase != 2 && guard < LOCK + 3) begin
         clean(1);
         guard++;
      end
      if (m_phase != 2) check("lock_bound", int'(locked), 1);
   endtask

   task automatic inject(input int v);
      drive(v, 1, 0, 1);
      cur = (v + 1) % MODV;
   endtask

   task automatic settle_check(input string name, input int act_sel, input int req);
      @(posedge clk);
      #3;
      case (act_sel)
         0: check(name, int'(locked), req);
         1: check(name, int'(err_pulse), req);
         2: check(name, int'(err_count), req);
         3: check(name, int'(sticky_err), req);
         4: check(name, int'(bad_value), req);
         default: check(name, int'(exp_value), req);
      endcase
   endtask

   // Monitor: outputs are presented every cycle, one scoreboard entry per sampled edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("locked",     int'(locked),     e.lk);
            check("err_pulse",  int'(err_pulse),  e.pulse);
            check("err_count",  int'(err_count),  e.cnt);
            check("sticky_err", int'(sticky_err), e.sticky);
            check("bad_value",  int'(bad_value),  e.bad);
            check("exp_value",  int'(exp_value),  e.expv);
         end
      end
   end

   initial begin
      int r, v, en, clr, rs, guard;

      // Clean count from zero with wraps
      do_reset();
      clean(4);
      settle_check("not_locked_edge4", 0, 0);
      clean(1);
      settle_check("locked_edge5", 0, 1);
      clean(36);

      // Jump 3 -> 5 while locked, then re-lock
      guard = 0;
      while (cur != 3 && guard < MODV) begin clean(1); guard++; end
      inject(5);
      settle_check("jump_bad", 4, 5);
      clean(3);
      settle_check("relock_pending", 0, 0);
      clean(1);
      settle_check("relock_4", 0, 1);

      // Hold at 7 with enable low, then illegal step to 8
      guard = 0;
      while (cur != 7 && guard < MODV) begin clean(1); guard++; end
      for (int i = 0; i < 10; i++) drive(7, 0, 0, 1);
      drive(8, 1, 0, 1);
      cur = 9;
      settle_check("hold_bad", 4, 8);
      clean(6);

      // Saturation of the error counter
      do_reset();
      for (int i = 0; i < 300; i++) begin
         lock_up();
         inject((cur + 2) % MODV);
      end
      settle_check("sat_count", 2, EMAX);
      clean(6);

      // Clear coincident with an error of 0xA
      do_reset();
      for (int i = 0; i < 3; i++) begin
         lock_up();
         inject((cur + 3) % MODV);
      end
      lock_up();
      guard = 0;
      while (cur == 10 && guard < 4) begin clean(1); guard++; end
      drive(10, 1, 1, 1);
      cur = 11;
      settle_check("clr_err_count", 2, 1);
      clean(6);

      // Reset mid-operation while locked with two errors
      do_reset();
      for (int i = 0; i < 2; i++) begin
         lock_up();
         inject((cur + 5) % MODV);
      end
      lock_up();
      drive(cur, 1, 0, 0);
      settle_check("rst_count", 2, 0);
      cur = 0;
      clean(4);
      clean(1);
      settle_check("rst_relock5", 0, 1);

      // Randomized traffic: mostly a legal counter with glitches, clears and rare resets
      for (int i = 0; i < 1500; i++) begin
         r   = $urandom_range(0, 199);
         rs  = (r == 0) ? 0 : 1;
         en  = ($urandom_range(0, 3) != 0) ? 1 : 0;
         clr = ($urandom_range(0, 24) == 0) ? 1 : 0;
         v   = (r < 12) ? $urandom_range(0, MODV - 1) : cur;
         drive(v, en, clr, rs);
         cur = (v + en) % MODV;
      end

      @(posedge clk);
      #2;
      guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
         @(posedge clk);
         #2;
         guard++;
      end
      if (exp_q.size() > 0) check("drain_bound", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
